// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit: extends an IN_W-bit field to OUT_W bits in one of four
// modes and queues results in a DEPTH-entry FIFO with valid/ready on both sides.
module imm_extend_pipe #(
   parameter int unsigned IN_W  = 23,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_data,
   input  logic [1:0]                 in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned XW = OUT_W - IN_W;

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW-1:0]    rd_next, wr_next;
   logic [CW-1:0]    count_next;
   logic [OUT_W-1:0] ext, zx, sx;
   logic [OUT_W-1:0] out_data_next;
   logic             push, pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Shifts on the zero/sign-extended value keep every replication width >= 2.
   always_comb begin
      zx  = {{XW{1'b0}}, in_data};
      sx  = {{XW{in_data[IN_W-1]}}, in_data};
      ext = zx;
      case (in_mode)
         2'b00:   ext = zx;
         2'b01:   ext = sx;
         2'b10:   ext = sx << 2;
         default: ext = zx << XW;
      endcase
   end

   // Next pointers/occupancy and the value that will sit at the head after the edge.
   always_comb begin
      rd_next       = rd_ptr;
      wr_next       = wr_ptr;
      count_next    = count;
      out_data_next = '0;
      if (flush) begin
         rd_next    = '0;
         wr_next    = '0;
         count_next = '0;
      end else begin
         if (pop)  rd_next = rd_ptr + AW'(1);
         if (push) wr_next = wr_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
         if (count_next != '0)
            out_data_next = (push && (wr_ptr == rd_next)) ? ext : mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
      end else begin
         rd_ptr    <= rd_next;
         wr_ptr    <= wr_next;
         count     <= count_next;
         out_valid <= (count_next != '0);
         out_data  <= out_data_next;
         in_ready  <= (count_next < CW'(DEPTH));
      end
   end

endmodule
